// File: rtl/gpu_parameters.sv
// Shared fp32 parameters, constants and operand class type for the core's
// floating-point units.
package gpu_parameters;

  localparam int DATA_WIDTH = 32;
  localparam int EXP_WIDTH  = 8;
  localparam int MANT_WIDTH = 23;
  localparam int BIAS       = 127;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational fp32 unpacker: splits a word into sign, exponent and a
// 24-bit mantissa with the hidden one, and classifies it. Denormals are
// reported as zero.
module fp_classify
  import gpu_parameters::*;
(
  input  logic [31:0]           word,
  output logic                  sign,
  output logic [EXP_WIDTH-1:0]  exponent,
  output logic [MANT_WIDTH:0]   mantissa,
  output fp_class_t             fp_class
);

  // Field extraction and class decode.
  always_comb begin
    sign     = word[31];
    exponent = word[MANT_WIDTH +: EXP_WIDTH];
    mantissa = {1'b1, word[MANT_WIDTH-1:0]};
    if (exponent == {EXP_WIDTH{1'b1}}) begin
      fp_class = (word[MANT_WIDTH-1:0] != '0) ? FP_NAN : FP_INF;
    end else if (exponent == '0) begin
      fp_class = FP_ZERO;
    end else begin
      fp_class = FP_NORMAL;
    end
  end

endmodule

// File: rtl/fp_div.sv
// Iterative fp32 divider: valid/ready operand accept, 27-cycle radix-2
// restoring mantissa division, round-to-nearest-even, and a result held
// until the consumer takes it. Denormal inputs read as zero and underflow
// flushes to zero.
module fp_div
  import gpu_parameters::*;
#(
  parameter int DATA_WIDTH = gpu_parameters::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic [3:0]            flags,
  output logic                  result_valid,
  input  logic                  result_ready
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $fatal(1, "fp_div: DATA_WIDTH must be 32");
  end

  typedef enum logic [2:0] {
    IDLE,
    DIVIDE,
    ROUND,
    DONE,
    SPECIAL_DONE
  } state_t;

  localparam logic [3:0] FLAG_INVALID   = 4'b1000;
  localparam logic [3:0] FLAG_DIV_ZERO  = 4'b0100;
  localparam logic [3:0] FLAG_OVERFLOW  = 4'b0010;
  localparam logic [3:0] FLAG_UNDERFLOW = 4'b0001;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [23:0]        mb_q, mb_d;
  logic [24:0]        rem_q, rem_d;
  logic [26:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               result_valid_q, result_valid_d;
  logic               in_ready_q, in_ready_d;

  logic               sign_a, sign_b;
  logic [7:0]         exp_a, exp_b;
  logic [23:0]        mant_a, mant_b;
  fp_class_t          class_a, class_b;

  fp_classify u_class_a (
    .word     (a),
    .sign     (sign_a),
    .exponent (exp_a),
    .mantissa (mant_a),
    .fp_class (class_a)
  );

  fp_classify u_class_b (
    .word     (b),
    .sign     (sign_b),
    .exponent (exp_b),
    .mantissa (mant_b),
    .fp_class (class_b)
  );

  logic               res_sign;
  logic signed [9:0]  exp_calc;
  logic               special_hit;
  logic [31:0]        special_result;
  logic [3:0]         special_flags;

  // Result sign, biased exponent difference and special-case selection.
  always_comb begin
    res_sign       = sign_a ^ sign_b;
    exp_calc       = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b})
                     + $signed(10'(BIAS));
    special_hit    = !((class_a == FP_NORMAL) && (class_b == FP_NORMAL));
    special_result = '0;
    special_flags  = '0;
    if ((class_a == FP_NAN) || (class_b == FP_NAN) ||
        ((class_a == FP_ZERO) && (class_b == FP_ZERO)) ||
        ((class_a == FP_INF) && (class_b == FP_INF))) begin
      special_result = FP32_QNAN;
      special_flags  = FLAG_INVALID;
    end else if (class_a == FP_INF) begin
      special_result = {res_sign, 8'hFF, 23'd0};
    end else if (class_b == FP_ZERO) begin
      special_result = {res_sign, 8'hFF, 23'd0};
      special_flags  = FLAG_DIV_ZERO;
    end else begin
      special_result = {res_sign, 31'd0};
    end
  end

  logic               rem_ge;
  logic [24:0]        rem_sub;
  logic [24:0]        rem_next;
  logic [26:0]        quo_next;

  // One restoring division step: compare, conditionally subtract, shift.
  always_comb begin
    rem_ge   = (rem_q >= {1'b0, mb_q});
    rem_sub  = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_next = {rem_sub[23:0], 1'b0};
    quo_next = {quo_q[25:0], rem_ge};
  end

  logic [23:0]        mant_pre;
  logic               guard_bit, round_bit, sticky_bit, round_up;
  logic signed [9:0]  exp_norm, exp_fin;
  logic [24:0]        mant_inc;
  logic [23:0]        mant_fin;
  logic [31:0]        round_result;
  logic [3:0]         round_flags;

  // Normalise the quotient, round to nearest-even, then range-check.
  always_comb begin
    if (quo_q[26]) begin
      mant_pre   = quo_q[26:3];
      guard_bit  = quo_q[2];
      round_bit  = quo_q[1];
      sticky_bit = quo_q[0] | (rem_q != '0);
      exp_norm   = exp_q;
    end else begin
      mant_pre   = quo_q[25:2];
      guard_bit  = quo_q[1];
      round_bit  = quo_q[0];
      sticky_bit = (rem_q != '0);
      exp_norm   = exp_q - 10'sd1;
    end
    round_up = guard_bit & (round_bit | sticky_bit | mant_pre[0]);
    mant_inc = {1'b0, mant_pre} + 25'(round_up);
    if (mant_inc[24]) begin
      mant_fin = 24'h800000;
      exp_fin  = exp_norm + 10'sd1;
    end else begin
      mant_fin = mant_inc[23:0];
      exp_fin  = exp_norm;
    end
    if (exp_fin >= 10'sd255) begin
      round_result = {sign_q, 8'hFF, 23'd0};
      round_flags  = FLAG_OVERFLOW;
    end else if (exp_fin <= 10'sd0) begin
      round_result = {sign_q, 31'd0};
      round_flags  = FLAG_UNDERFLOW;
    end else begin
      round_result = {sign_q, exp_fin[7:0], mant_fin[22:0]};
      round_flags  = '0;
    end
  end

  // Next-state and datapath update for the accept/divide/round/hold sequence.
  always_comb begin
    state_d        = state_q;
    sign_d         = sign_q;
    exp_d          = exp_q;
    mb_d           = mb_q;
    rem_d          = rem_q;
    quo_d          = quo_q;
    cnt_d          = cnt_q;
    result_d       = result_q;
    flags_d        = flags_q;
    result_valid_d = result_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d = res_sign;
          if (special_hit) begin
            result_d       = special_result;
            flags_d        = special_flags;
            result_valid_d = 1'b1;
            state_d        = SPECIAL_DONE;
          end else begin
            exp_d   = exp_calc;
            mb_d    = mant_b;
            rem_d   = {1'b0, mant_a};
            quo_d   = '0;
            cnt_d   = 5'd26;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        result_d       = round_result;
        flags_d        = round_flags;
        result_valid_d = 1'b1;
        state_d        = DONE;
      end
      DONE, SPECIAL_DONE: begin
        if (result_valid_q && result_ready) begin
          result_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      sign_q         <= 1'b0;
      exp_q          <= '0;
      mb_q           <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      cnt_q          <= '0;
      result_q       <= '0;
      flags_q        <= '0;
      result_valid_q <= 1'b0;
      in_ready_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sign_q         <= sign_d;
      exp_q          <= exp_d;
      mb_q           <= mb_d;
      rem_q          <= rem_d;
      quo_q          <= quo_d;
      cnt_q          <= cnt_d;
      result_q       <= result_d;
      flags_q        <= flags_d;
      result_valid_q <= result_valid_d;
      in_ready_q     <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign result       = result_q;
  assign flags        = flags_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_fp_div.sv
// Directed scoreboard bench for fp_div: expected results are queued when
// operands are driven and compared when result_valid appears.
module tb_fp_div;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic [3:0]  flags;
  logic        result_valid;
  logic        result_ready;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
    string       tag;
  } expect_t;

  expect_t sb[$];
  int      checks = 0;
  int      errors = 0;
  int      cycles = 0;

  fp_div #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .result       (result),
    .flags        (flags),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkEq(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one operand pair, queue its expectation, and wait for the accept.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] er, input logic [3:0] ef,
                               input int el, input string tag);
    expect_t e;
    int waited;
    e.res = er; e.flg = ef; e.lat = el; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkEq({tag, "_accept_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 1;
  endtask

  // Wait (bounded) for the result, pop the scoreboard and compare.
  task automatic checkOutput();
    expect_t e;
    while (!result_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty: observed=0 expected=1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkEq({e.tag, "_valid"},   {31'd0, result_valid}, 32'd1);
      checkEq({e.tag, "_result"},  result, e.res);
      checkEq({e.tag, "_flags"},   {28'd0, flags}, {28'd0, e.flg});
      checkEq({e.tag, "_latency"}, cycles, e.lat);
    end
  endtask

  // Complete the result handshake and confirm the block is idle again.
  task automatic completeHandshake(input string tag);
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    checkEq({tag, "_valid_dropped"}, {31'd0, result_valid}, 32'd0);
    checkEq({tag, "_ready_rose"},    {31'd0, in_ready},     32'd1);
  endtask

  task automatic runOp(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic [3:0] ef,
                       input int el, input string tag);
    applyStimulus(av, bv, er, ef, el, tag);
    checkOutput();
    completeHandshake(tag);
  endtask

  // Directed sequence: reset, arithmetic, specials, backpressure, abort.
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    result_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    checkEq("reset_in_ready", {31'd0, in_ready},     32'd0);
    checkEq("reset_valid",    {31'd0, result_valid}, 32'd0);
    checkEq("reset_result",   result,                32'd0);
    checkEq("reset_flags",    {28'd0, flags},        32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkEq("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    runOp(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29, "six_by_two");
    runOp(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29, "one_by_three");
    runOp(32'h41200000, 32'h40800000, 32'h40200000, 4'b0000, 29, "ten_by_four");
    runOp(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 29, "neg_six_by_two");
    runOp(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 29, "one_by_one");
    runOp(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 29, "overflow");
    runOp(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 29, "underflow");

    runOp(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 1, "div_by_zero");
    runOp(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, "zero_by_zero");
    runOp(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, "nan_operand");
    runOp(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1, "inf_by_inf");
    runOp(32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 1, "inf_by_finite");
    runOp(32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 1, "finite_by_inf");
    runOp(32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1, "denorm_dividend");
    runOp(32'h3F800000, 32'h00000001, 32'h7F800000, 4'b0100, 1, "denorm_divisor");

    // Backpressure: result held five cycles while a second operand waits.
    applyStimulus(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 29, "bp_first");
    checkOutput();
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    sb.push_back('{res: 32'h40400000, flg: 4'b0000, lat: 29, tag: "bp_second"});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkEq("bp_hold_result",   result,                32'h3EAAAAAB);
      checkEq("bp_hold_flags",    {28'd0, flags},        32'd0);
      checkEq("bp_hold_valid",    {31'd0, result_valid}, 32'd1);
      checkEq("bp_hold_in_ready", {31'd0, in_ready},     32'd0);
    end
    completeHandshake("bp_first");
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 1;
    checkEq("bp_second_accepted", {31'd0, in_ready}, 32'd0);
    checkOutput();
    completeHandshake("bp_second");

    // Reset in the middle of a division discards it completely.
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkEq("abort_valid",    {31'd0, result_valid}, 32'd0);
    checkEq("abort_result",   result,                32'd0);
    checkEq("abort_flags",    {28'd0, flags},        32'd0);
    checkEq("abort_in_ready", {31'd0, in_ready},     32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkEq("abort_release_in_ready", {31'd0, in_ready},     32'd1);
    checkEq("abort_release_valid",    {31'd0, result_valid}, 32'd0);
    runOp(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29, "after_abort");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_div.md
# fp_div

Iterative IEEE 754 single-precision divider for the fp32 core. It is the inverse-operation companion to the pipelined multiplier in the same core. It accepts one operand pair through a valid/ready handshake and runs a radix-2 restoring mantissa division over 27 cycles. It then rounds to nearest-even and holds the packed result until the consumer takes it. Denormal inputs are treated as zero and underflowing results are flushed to zero, which matches the multiplier's result behaviour.

## Interface
Parameters:
- DATA_WIDTH, from gpu_parameters (32): operand/result width. Elaboration must `$fatal` if it is not 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  high only in IDLE; reset value 0 while rst is asserted, 1 after release.
- a  in  DATA_WIDTH  dividend.
- b  in  DATA_WIDTH  divisor.
- result  out  DATA_WIDTH  quotient; reset value 0.
- flags  out  4  {invalid, div_by_zero, overflow, underflow}, valid with result; reset value 0.
- result_valid  out  1  result/flags held stable while high; reset value 0.
- result_ready  in  1  consumer accepts the result.

## Operation
States:
- IDLE -> SPECIAL_DONE on accept when a special case applies.
- IDLE -> DIVIDE on accept otherwise.
- DIVIDE -> ROUND when the iteration counter reaches 0.
- ROUND -> DONE.
- DONE -> IDLE on result_valid && result_ready.

Accept and classify:
- Accept happens on a rising edge with in_valid && in_ready.
- Operands are registered at accept.
- Sign of the result is sign(a) XOR sign(b).
- Classes: NaN (exp=255, frac≠0), Inf (exp=255, frac=0), Zero (exp=0, any frac, i.e. denormals are zero), Normal.

Special results, evaluated in priority order and loaded directly into result:
- Any NaN operand, 0/0, or Inf/Inf -> 0x7FC00000, invalid=1.
- Inf/finite -> signed Inf.
- Normal/0 -> signed Inf, div_by_zero=1.
- 0/finite or finite/Inf -> signed zero.

Normal path:
- Mantissas ma={1,frac_a}, mb={1,frac_b}, 24 bits each.
- Exponent e = exp_a − exp_b + 127, computed as a signed 10-bit value.
- Division: r starts at ma (25 bits). The 5-bit counter loads 26. Each DIVIDE cycle:
  - q bit = (r ≥ mb);
  - if the bit is 1, r −= mb;
  - r <<= 1;
  - the q bit shifts into a 27-bit quotient register q.
- Normalisation:
  - If q[26]=1: mantissa = q[26:3], G=q[2], R=q[1], S=q[0]|(r≠0).
  - Otherwise: mantissa = q[25:2], G=q[1], R=q[0], S=(r≠0), and e −= 1.
- Rounding: round up when G && (R || S || lsb). A carry out of the 24-bit mantissa sets mantissa to 1.0 and increments e.
- Result selection after rounding:
  - e ≥ 255 -> signed Inf, overflow=1.
  - e ≤ 0 -> signed zero, underflow=1.
  - Otherwise pack {sign, e[7:0], mantissa[22:0]}.

Boundary behaviour:
- in_valid while not IDLE is ignored; in_ready is low, so operands are not sampled.
- result, flags and result_valid are stable in DONE until the handshake completes.
- rst asserted in any state aborts the operation. The block returns to IDLE and all outputs take their reset values, with no partial result emitted.
- There is no same-cycle turnaround: after the result handshake, in_ready rises the following cycle (IDLE).

## Timing
- Accept edge at T0.
- Normal path: DIVIDE occupies edges T1..T27, ROUND at T28, and result_valid is high from T29 (latency 29 cycles).
- Special path: result_valid is high in the cycle after T0 (latency 1).
- result_valid drops on the edge where result_ready is sampled high. in_ready rises the same edge.
- Throughput: one operation per latency + 1 cycle, assuming result_ready is held high.

## Structure
- gpu_parameters gains shared FP32 constants: EXP_WIDTH=8, MANT_WIDTH=23, BIAS=127, FP32_QNAN=32'h7FC00000, plus an fp_class_t enum {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN}. fp_mul uses the same items.
- The state enum is local to fp_div.
- One natural sub-module: fp_classify. It is combinational, taking a 32-bit word and producing sign, exp, 24-bit mantissa and fp_class_t. It is reusable by fp_mul.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> 0x40400000, flags 0, result_valid exactly 29 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB (G=1, S=1 round-up), flags 0.
- 0xBF800000 / 0x00000000 -> 0xFF800000 with div_by_zero. 0x00000000 / 0x00000000 -> 0x7FC00000 with invalid. Both with result_valid 1 cycle after accept.
- 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 with overflow. 0x00800000 / 0x40000000 -> 0x00000000 with underflow.
- Backpressure:
  - hold result_ready low for 5 cycles in DONE -> result and flags unchanged, in_ready low;
  - a second in_valid presented during this window is not accepted;
  - after the handshake, the next operation is accepted on the following cycle.
- Assert rst mid-DIVIDE (T10) -> result_valid=0, result=0, in_ready=1 after release. A fresh 6/2 then yields 0x40400000.
